// File: rtl/stoch_frame_sng.sv
// stoch_frame_sng: stochastic number generator stage fed by an LFSR tap.
// Converts a binary probability (latched on START) into a unipolar
// bitstream of 2^FRAME_BITS bits by comparing it against one random word
// per clock, and counts the ones emitted in the frame.
// Ports:
//   TRIG       clock, rising edge
//   RESET      asynchronous reset, active-high
//   START      frame request, accepted in IDLE or DONE
//   ABORT      terminate a running frame (ignored outside RUN)
//   PROB       probability p, encodes p/2^WIDTH, latched when START accepted
//   RAND       random word, consumed every clock in RUN
//   BIT_OUT    registered stochastic bit
//   BIT_VALID  BIT_OUT carries a frame bit
//   BUSY       frame running
//   DONE       one-cycle pulse after a frame completes normally
//   ONES       ones counted in the current / last frame
module stoch_frame_sng #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned FRAME_BITS = 8
) (
   input  logic                  TRIG,
   input  logic                  RESET,
   input  logic                  START,
   input  logic                  ABORT,
   input  logic [WIDTH-1:0]      PROB,
   input  logic [WIDTH-1:0]      RAND,
   output logic                  BIT_OUT,
   output logic                  BIT_VALID,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [FRAME_BITS:0]   ONES
);

   localparam int unsigned ONES_W = FRAME_BITS + 1;
   localparam logic [FRAME_BITS-1:0] CNT_LAST = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      p_q, p_d;
   logic [FRAME_BITS-1:0] cnt_q, cnt_d;
   logic [ONES_W-1:0]     ones_d;
   logic                  bit_d, valid_d, busy_d, done_d;
   logic                  hit;

   // Stochastic comparison: one with probability p/2^WIDTH for uniform RAND
   assign hit = (RAND < p_q);

   // Next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      ones_d  = ONES;
      bit_d   = BIT_OUT;
      valid_d = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (START) begin
               p_d     = PROB;
               cnt_d   = '0;
               ones_d  = '0;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            // Abort wins over frame end; partial count is kept
            if (ABORT) begin
               state_d = S_IDLE;
            end else begin
               bit_d   = hit;
               valid_d = 1'b1;
               ones_d  = ONES + ONES_W'(hit);
               cnt_d   = cnt_q + FRAME_BITS'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            // Pulse DONE on leaving; START here chains the next frame
            done_d = 1'b1;
            if (START) begin
               p_d     = PROB;
               cnt_d   = '0;
               ones_d  = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_RUN);
   end

   // State and output registers
   always_ff @(posedge TRIG or posedge RESET) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         p_q       <= '0;
         cnt_q     <= '0;
         ONES      <= '0;
         BIT_OUT   <= 1'b0;
         BIT_VALID <= 1'b0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
      end else begin
         state_q   <= state_d;
         p_q       <= p_d;
         cnt_q     <= cnt_d;
         ONES      <= ones_d;
         BIT_OUT   <= bit_d;
         BIT_VALID <= valid_d;
         BUSY      <= busy_d;
         DONE      <= done_d;
      end
   end

endmodule
